// File: rtl/rf_pkg.sv
// Shared constants for the register-file write arbiter and its scoreboard.
package rf_pkg;

    localparam logic [4:0] REG_ZERO             = 5'd0;
    localparam int         DEFAULT_STARVE_LIMIT = 3;

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_WB   = 2'b01,
        GNT_MD   = 2'b10
    } grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write bitmap for MUL/DIV destinations with two combinational lookups.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] chk_addr_1,
    input  logic [ADDR_WIDTH-1:0] chk_addr_2,
    output logic                  hit_1,
    output logic                  hit_2,
    output logic [31:0]           pending
);

    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] pending_next;

    // A set is applied after the clear, so a newly issued op keeps its bit.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && (set_addr != ADDR_WIDTH'(REG_ZERO))) begin
            set_mask = 32'd1 << set_addr;
        end
        if (clr_en) begin
            clr_mask = 32'd1 << clr_addr;
        end
        pending_next    = (pending & ~clr_mask) | set_mask;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign hit_1 = pending[chk_addr_1];
    assign hit_2 = pending[chk_addr_2];

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between writeback and MUL/DIV,
// with a starvation guard for MUL/DIV and a pending-write scoreboard for decode.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ0_DATA,
    output logic                  REQ0_READY,
    input  logic                  REQ1_VALID,
    input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ1_DATA,
    output logic                  REQ1_READY,
    input  logic                  ISSUE_EN,
    input  logic [ADDR_WIDTH-1:0] ISSUE_ADDR,
    input  logic [ADDR_WIDTH-1:0] CHK_ADDR_1,
    input  logic [ADDR_WIDTH-1:0] CHK_ADDR_2,
    output logic                  HAZARD_1,
    output logic                  HAZARD_2,
    output logic                  WRITE_EN,
    output logic [ADDR_WIDTH-1:0] WRITE_ADDR,
    output logic [DATA_WIDTH-1:0] WRITE_DATA,
    output logic [31:0]           PENDING
);

    grant_e     grant;
    logic [2:0] starve_cnt;

    // Starved MUL/DIV overrides writeback; otherwise writeback has priority.
    always_comb begin
        grant = GNT_NONE;
        if (!RESET) begin
            if (REQ1_VALID && (starve_cnt == 3'(STARVE_LIMIT))) begin
                grant = GNT_MD;
            end else if (REQ0_VALID) begin
                grant = GNT_WB;
            end else if (REQ1_VALID) begin
                grant = GNT_MD;
            end
        end
    end

    assign REQ0_READY = (grant == GNT_WB);
    assign REQ1_READY = (grant == GNT_MD);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_cnt <= '0;
        end else if (!REQ1_VALID || REQ1_READY) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 3'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WRITE_EN   <= 1'b0;
            WRITE_ADDR <= '0;
            WRITE_DATA <= '0;
        end else begin
            case (grant)
                GNT_WB: begin
                    WRITE_EN   <= (REQ0_ADDR != ADDR_WIDTH'(REG_ZERO));
                    WRITE_ADDR <= REQ0_ADDR;
                    WRITE_DATA <= REQ0_DATA;
                end
                GNT_MD: begin
                    WRITE_EN   <= (REQ1_ADDR != ADDR_WIDTH'(REG_ZERO));
                    WRITE_ADDR <= REQ1_ADDR;
                    WRITE_DATA <= REQ1_DATA;
                end
                default: begin
                    WRITE_EN <= 1'b0;
                end
            endcase
        end
    end

    rf_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_scoreboard (
        .clk        (CLK),
        .reset      (RESET),
        .set_en     (ISSUE_EN),
        .set_addr   (ISSUE_ADDR),
        .clr_en     (REQ1_READY),
        .clr_addr   (REQ1_ADDR),
        .chk_addr_1 (CHK_ADDR_1),
        .chk_addr_2 (CHK_ADDR_2),
        .hit_1      (HAZARD_1),
        .hit_2      (HAZARD_2),
        .pending    (PENDING)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed, table-driven bench for rf_write_arbiter (STARVE_LIMIT = 3).
module tb_rf_write_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        REQ0_VALID, REQ1_VALID, ISSUE_EN;
    logic [4:0]  REQ0_ADDR, REQ1_ADDR, ISSUE_ADDR, CHK_ADDR_1, CHK_ADDR_2;
    logic [31:0] REQ0_DATA, REQ1_DATA;
    logic        REQ0_READY, REQ1_READY, HAZARD_1, HAZARD_2, WRITE_EN;
    logic [4:0]  WRITE_ADDR;
    logic [31:0] WRITE_DATA, PENDING;

    int vectors_applied = 0;
    int miscompares     = 0;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        iss;
        logic [4:0]  ia;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        e_r0;
        logic        e_r1;
        logic        e_h1;
        logic        e_h2;
        logic        e_we;
        logic        cw;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_pend;
    } vec_t;

    vec_t tbl[$];

    rf_write_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .STARVE_LIMIT(3)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
        .ISSUE_EN(ISSUE_EN), .ISSUE_ADDR(ISSUE_ADDR),
        .CHK_ADDR_1(CHK_ADDR_1), .CHK_ADDR_2(CHK_ADDR_2),
        .HAZARD_1(HAZARD_1), .HAZARD_2(HAZARD_2),
        .WRITE_EN(WRITE_EN), .WRITE_ADDR(WRITE_ADDR), .WRITE_DATA(WRITE_DATA),
        .PENDING(PENDING)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(
        input logic rst, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
        input logic iss, input logic [4:0] ia, input logic [4:0] c1, input logic [4:0] c2,
        input logic r0, input logic r1, input logic h1, input logic h2,
        input logic we, input logic cw, input logic [4:0] wa, input logic [31:0] wd,
        input logic [31:0] pend);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.iss = iss; v.ia = ia; v.c1 = c1; v.c2 = c2;
        v.e_r0 = r0; v.e_r1 = r1; v.e_h1 = h1; v.e_h2 = h2;
        v.e_we = we; v.cw = cw; v.e_wa = wa; v.e_wd = wd; v.e_pend = pend;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx, input logic [31:0] actual, input logic [31:0] expected);
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s (vector %0d): got 0x%08h, expected 0x%08h", name, idx, actual, expected);
        end
    endtask

    // Drive at negedge, check combinational outputs, then check registered ones after the edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge CLK);
        RESET      = v.rst;
        REQ0_VALID = v.v0; REQ0_ADDR = v.a0; REQ0_DATA = v.d0;
        REQ1_VALID = v.v1; REQ1_ADDR = v.a1; REQ1_DATA = v.d1;
        ISSUE_EN   = v.iss; ISSUE_ADDR = v.ia;
        CHK_ADDR_1 = v.c1; CHK_ADDR_2 = v.c2;
        vectors_applied++;
        #1;
        checkOutput("REQ0_READY", idx, 32'(REQ0_READY), 32'(v.e_r0));
        checkOutput("REQ1_READY", idx, 32'(REQ1_READY), 32'(v.e_r1));
        checkOutput("HAZARD_1",   idx, 32'(HAZARD_1),   32'(v.e_h1));
        checkOutput("HAZARD_2",   idx, 32'(HAZARD_2),   32'(v.e_h2));
        @(posedge CLK);
        #1;
        checkOutput("WRITE_EN", idx, 32'(WRITE_EN), 32'(v.e_we));
        checkOutput("PENDING",  idx, PENDING, v.e_pend);
        if (v.cw) begin
            checkOutput("WRITE_ADDR", idx, 32'(WRITE_ADDR), 32'(v.e_wa));
            checkOutput("WRITE_DATA", idx, WRITE_DATA, v.e_wd);
        end
    endtask

    initial begin
        // Power-on reset: READY must stay low even with a valid request present.
        RESET = 1'b1;
        REQ0_VALID = 1'b1; REQ0_ADDR = 5'd5; REQ0_DATA = 32'h1111_1111;
        REQ1_VALID = 1'b0; REQ1_ADDR = 5'd0; REQ1_DATA = 32'h0;
        ISSUE_EN = 1'b0; ISSUE_ADDR = 5'd0; CHK_ADDR_1 = 5'd0; CHK_ADDR_2 = 5'd0;
        tbl.push_back(mk(1, 1, 5'd5, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 5'd0, 32'h0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 5'd0, 32'h0, 32'h0));
        // Single writeback request and following idle cycle
        tbl.push_back(mk(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 5'd5, 32'hDEAD_BEEF, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 5'd5, 32'hDEAD_BEEF, 32'h0));
        // x0 transfer and x0 issue
        tbl.push_back(mk(0, 1, 5'd0, 32'h1234, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 32'h0));
        // Issue to r7, hazard next cycle, MUL/DIV completes, hazard drops after
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0,  0, 0, 0, 0,  0, 0, 0, 0, 32'h80));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0,  0, 0, 1, 0,  0, 0, 0, 0, 32'h80));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5'd7, 32'hCAFE_F00D, 0, 0, 5'd7, 0,  0, 1, 1, 0,  1, 1, 5'd7, 32'hCAFE_F00D, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0,  0, 0, 0, 0,  0, 1, 5'd7, 32'hCAFE_F00D, 32'h0));
        // Same-cycle issue and clear of r9: set wins
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 5'd9,  0, 0, 0, 0,  0, 1, 5'd7, 32'hCAFE_F00D, 32'h200));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd9, 0, 5'd9,  0, 1, 0, 1,  1, 1, 5'd9, 32'h99, 32'h200));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9,  0, 0, 0, 1,  0, 1, 5'd9, 32'h99, 32'h200));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5'd9, 32'h5, 0, 0, 0, 5'd9,  0, 1, 0, 1,  1, 1, 5'd9, 32'h5, 32'h0));
        // Writeback to a pending register leaves the bit alone
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 0, 0,  0, 0, 0, 0,  0, 1, 5'd9, 32'h5, 32'h8));
        tbl.push_back(mk(0, 1, 5'd3, 32'h33, 0, 0, 0, 0, 0, 5'd3, 0,  1, 0, 1, 0,  1, 1, 5'd3, 32'h33, 32'h8));
        tbl.push_back(mk(0, 0, 0, 0, 1, 5'd3, 32'h44, 0, 0, 5'd3, 0,  0, 1, 1, 0,  1, 1, 5'd3, 32'h44, 32'h0));
        // Starvation 3:1 with hazard visible while REQ1 waits
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0,  0, 0, 0, 0,  0, 1, 5'd3, 32'h44, 32'h10));
        tbl.push_back(mk(0, 1, 5'd1, 32'h11, 1, 5'd4, 32'h44, 0, 0, 5'd4, 0,  1, 0, 1, 0,  1, 1, 5'd1, 32'h11, 32'h10));
        tbl.push_back(mk(0, 1, 5'd2, 32'h22, 1, 5'd4, 32'h44, 0, 0, 5'd4, 5'd2,  1, 0, 1, 0,  1, 1, 5'd2, 32'h22, 32'h10));
        tbl.push_back(mk(0, 1, 5'd6, 32'h66, 1, 5'd4, 32'h44, 0, 0, 5'd4, 0,  1, 0, 1, 0,  1, 1, 5'd6, 32'h66, 32'h10));
        tbl.push_back(mk(0, 1, 5'd8, 32'h88, 1, 5'd4, 32'h44, 0, 0, 5'd4, 0,  0, 1, 1, 0,  1, 1, 5'd4, 32'h44, 32'h0));
        tbl.push_back(mk(0, 1, 5'd8, 32'h88, 1, 5'd10, 32'hAA, 0, 0, 5'd4, 0,  1, 0, 0, 0,  1, 1, 5'd8, 32'h88, 32'h0));
        tbl.push_back(mk(0, 1, 5'd12, 32'hC, 1, 5'd10, 32'hAA, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 5'd12, 32'hC, 32'h0));
        tbl.push_back(mk(0, 1, 5'd13, 32'hD, 1, 5'd10, 32'hAA, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 5'd13, 32'hD, 32'h0));
        tbl.push_back(mk(0, 1, 5'd14, 32'hE, 1, 5'd10, 32'hAA, 0, 0, 0, 0,  0, 1, 0, 0,  1, 1, 5'd10, 32'hAA, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 5'd10, 32'hAA, 32'h0));
        // MUL/DIV alone is granted immediately
        tbl.push_back(mk(0, 0, 0, 0, 1, 5'd5, 32'h55, 0, 0, 0, 0,  0, 1, 0, 0,  1, 1, 5'd5, 32'h55, 32'h0));
        // Reset mid-operation with PENDING=0x880 and counter at 2
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, 0,  0, 0, 0, 0,  0, 1, 5'd5, 32'h55, 32'h80));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5'd11, 0, 0,  0, 0, 0, 0,  0, 1, 5'd5, 32'h55, 32'h880));
        tbl.push_back(mk(0, 1, 5'd1, 32'h101, 1, 5'd2, 32'h202, 0, 0, 5'd7, 5'd11,  1, 0, 1, 1,  1, 1, 5'd1, 32'h101, 32'h880));
        tbl.push_back(mk(0, 1, 5'd1, 32'h102, 1, 5'd2, 32'h202, 0, 0, 5'd7, 5'd11,  1, 0, 1, 1,  1, 1, 5'd1, 32'h102, 32'h880));
        tbl.push_back(mk(1, 1, 5'd1, 32'h103, 1, 5'd2, 32'h202, 0, 0, 5'd7, 5'd11,  0, 0, 1, 1,  0, 1, 5'd0, 32'h0, 32'h0));
        tbl.push_back(mk(0, 1, 5'd1, 32'h103, 1, 5'd2, 32'h202, 0, 0, 5'd7, 5'd11,  1, 0, 0, 0,  1, 1, 5'd1, 32'h103, 32'h0));
        tbl.push_back(mk(0, 1, 5'd1, 32'h104, 1, 5'd2, 32'h202, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 5'd1, 32'h104, 32'h0));
        tbl.push_back(mk(0, 1, 5'd1, 32'h105, 1, 5'd2, 32'h202, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 5'd1, 32'h105, 32'h0));
        tbl.push_back(mk(0, 1, 5'd1, 32'h106, 1, 5'd2, 32'h202, 0, 0, 0, 0,  0, 1, 0, 0,  1, 1, 5'd2, 32'h202, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 5'd2, 32'h202, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i], i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - requester 0: the pipeline writeback stage;
  - requester 1: the multi-cycle MUL/DIV unit.
- Fixed priority to writeback, with a starvation guard for MUL/DIV.
- Keeps a pending-write scoreboard for MUL/DIV destinations so that decode can detect RAW hazards.
- Outputs are registered and drive the register file's WRITE_EN/WRITE_ADDR/WRITE_DATA; the register file commits on the following negedge.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register address width (32 registers).
- STARVE_LIMIT, 3, consecutive lost cycles after which requester 1 is force-granted (1..7).

Ports:
- CLK  in  1  clock, rising-edge logic.
- RESET  in  1  synchronous, active-high reset.
- REQ0_VALID  in  1  writeback has a result.
- REQ0_ADDR  in  ADDR_WIDTH  writeback destination.
- REQ0_DATA  in  DATA_WIDTH  writeback data.
- REQ0_READY  out  1  writeback accepted this cycle.
- REQ1_VALID  in  1  MUL/DIV has a result.
- REQ1_ADDR  in  ADDR_WIDTH  MUL/DIV destination.
- REQ1_DATA  in  DATA_WIDTH  MUL/DIV data.
- REQ1_READY  out  1  MUL/DIV accepted this cycle.
- ISSUE_EN  in  1  a MUL/DIV op is issued this cycle.
- ISSUE_ADDR  in  ADDR_WIDTH  destination of the issued op.
- CHK_ADDR_1  in  ADDR_WIDTH  decode source 1.
- CHK_ADDR_2  in  ADDR_WIDTH  decode source 2.
- HAZARD_1  out  1  source 1 has a pending MUL/DIV write.
- HAZARD_2  out  1  source 2 has a pending MUL/DIV write.
- WRITE_EN  out  1  register-file write enable (registered).
- WRITE_ADDR  out  ADDR_WIDTH  register-file write address (registered).
- WRITE_DATA  out  DATA_WIDTH  register-file write data (registered).
- PENDING  out  32  scoreboard bitmap, for debug.

Behaviour:
- Reset (synchronous, rising CLK with RESET=1):
  - WRITE_EN=0, WRITE_ADDR=0, WRITE_DATA=0, PENDING=0, starvation counter=0.
  - Any in-flight write or pending bit is discarded.
  - READY outputs are 0 while RESET is high.
- Handshake: a transfer occurs when VALID&&READY on a rising edge. READY is combinational from VALIDs and the counter. At most one READY is high per cycle.
- Grant rule:
  - If REQ1_VALID and counter==STARVE_LIMIT: REQ1_READY=1, REQ0_READY=0.
  - Else if REQ0_VALID: REQ0_READY=1.
  - Else if REQ1_VALID: REQ1_READY=1.
- Starvation counter:
  - Increments when REQ1_VALID && !REQ1_READY, saturating at STARVE_LIMIT.
  - Clears on a REQ1 transfer or when REQ1_VALID=0.
- Latency: the accepted request appears on WRITE_* on the next rising edge, and the register file commits it at the following negedge.
- Idle cycle: WRITE_EN=0; WRITE_ADDR and WRITE_DATA hold their previous values.
- x0: a transfer with ADDR==0 is accepted (READY follows the normal rule) but registers WRITE_EN=0. ISSUE_EN with ISSUE_ADDR==0 sets no bit. PENDING[0] is always 0.
- Scoreboard:
  - ISSUE_EN sets PENDING[ISSUE_ADDR].
  - A REQ1 transfer clears PENDING[REQ1_ADDR].
  - If the same address is both set and cleared in one cycle, set wins (a new op overrides).
  - A REQ0 transfer does not modify PENDING.
- Hazards:
  - HAZARD_n = PENDING[CHK_ADDR_n], combinational.
  - HAZARD_n also goes high when REQ1 holds CHK_ADDR_n but is not yet accepted, since that bit is still set.
  - No bypass from a same-cycle clear: HAZARD drops the cycle after the clear.
- Requester VALID/ADDR/DATA must stay stable while VALID && !READY. The arbiter does not buffer.

Decomposition:
- Shared package (rf_pkg):
  - REG_ZERO address constant.
  - Grant encoding constants: GNT_NONE=2'b00, GNT_WB=2'b01, GNT_MD=2'b10.
  - Default STARVE_LIMIT.
- One sub-module, rf_scoreboard:
  - 32-bit set/clear bitmap with set-priority and x0 masking.
  - Two combinational lookup ports.
- Arbitration, counter and output registers stay in the top module.

Test Plan:
- Single request: RESET 1 cycle, then REQ0 valid addr 5 data 0xDEADBEEF, REQ1 idle -> REQ0_READY=1 same cycle; next edge WRITE_EN=1, WRITE_ADDR=5, WRITE_DATA=0xDEADBEEF; the following cycle WRITE_EN=0.
- Starvation: REQ0 and REQ1 valid continuously, STARVE_LIMIT=3 -> REQ0 granted 3 cycles, REQ1 granted on the 4th, then REQ0 again; repeating pattern 3:1.
- x0 handling: REQ0 transfer to addr 0 data 0x1234 -> READY=1, WRITE_EN stays 0. ISSUE_EN to addr 0 -> PENDING=0.
- Scoreboard set/clear:
  - ISSUE_EN addr 7; CHK_ADDR_1=7 -> HAZARD_1=1 from the next cycle.
  - REQ1 transfer addr 7 -> HAZARD_1=0 the cycle after.
  - Same cycle: ISSUE_EN addr 9 plus REQ1 transfer addr 9 -> PENDING[9] stays 1.
- Reset mid-operation: PENDING=0x0000_0880 and REQ1 waiting with counter=2; assert RESET -> next edge PENDING=0, WRITE_EN=0, counter=0; after release, REQ0 wins the next contended cycle.
